bpsk_symbol_gen: RTL and testbench

//  Framed BPSK symbol source feeding the RRC FIR (myfir) in the clk_50m domain; replaces the 3 MHz bit_stream + async sampling.

---
 rtl/bpsk_pkg.sv | 23 ++
 rtl/bpsk_symbol_gen_if.sv | 23 ++
 rtl/prbs9_lfsr.sv | 26 ++
 rtl/bpsk_symbol_gen.sv | 125 ++++++++++++
 tb/tb_bpsk_symbol_gen.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bpsk_pkg.sv
// Shared types and constants for the framed BPSK symbol source.
// Symbol codes are the 2-bit signed values fed straight into the RRC FIR input.
package bpsk_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      PAYLOAD  = 2'd2,
      GUARD    = 2'd3
   } bpsk_state_e;

   localparam logic [1:0] SYM_POS  = 2'b01;
   localparam logic [1:0] SYM_NEG  = 2'b11;
   localparam logic [1:0] SYM_ZERO = 2'b00;

   localparam int         PRBS9_TAP  = 4;
   localparam logic [8:0] PRBS9_ONES = 9'h1FF;

   function automatic logic [1:0] sym_map(input logic b);
      return b ? SYM_POS : SYM_NEG;
   endfunction

endpackage

// File: rtl/bpsk_symbol_gen_if.sv
// Control and symbol-stream signals between the BPSK generator and its user.
// The generator sits on the master side; the controller/FIR side uses slave.
interface bpsk_symbol_gen_if;
   logic       en;
   logic       zero_stuff;
   logic [8:0] seed;
   logic       load_seed;
   logic       sym_tick;
   logic       bit_out;
   logic [1:0] din;
   logic       frame_start;
   logic       busy;

   modport master (
      input  en, zero_stuff, seed, load_seed,
      output sym_tick, bit_out, din, frame_start, busy
   );

   modport slave (
      output en, zero_stuff, seed, load_seed,
      input  sym_tick, bit_out, din, frame_start, busy
   );
endinterface

// File: rtl/prbs9_lfsr.sv
// PRBS9 (x^9+x^5+1) Fibonacci generator; the output bit is the register MSB.
// An all-zero seed would lock the register up, so it is replaced by all ones.
module prbs9_lfsr
   import bpsk_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       adv,
   input  logic       load,
   input  logic [8:0] seed,
   output logic       prbs_bit,
   output logic [8:0] state
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= PRBS9_ONES;
      else if (load)
         state <= (seed == 9'd0) ? PRBS9_ONES : seed;
      else if (adv)
         state <= {state[7:0], state[8] ^ state[PRBS9_TAP]};
   end

   assign prbs_bit = state[8];

endmodule

// File: rtl/bpsk_symbol_gen.sv
// Framed BPSK symbol source: preamble / PRBS9 payload / guard frames at clk/CLK_DIV.
// All outputs are registered one clk behind the divider/FSM state they describe.
module bpsk_symbol_gen
   import bpsk_pkg::*;
#(
   parameter int CLK_DIV      = 17,
   parameter int PREAMBLE_LEN = 32,
   parameter int PAYLOAD_LEN  = 256,
   parameter int GUARD_LEN    = 8
) (
   input logic               clk,
   input logic               rst_n,
   bpsk_symbol_gen_if.master bus
);

   localparam int MAX_PG  = (PAYLOAD_LEN > GUARD_LEN) ? PAYLOAD_LEN : GUARD_LEN;
   localparam int MAX_LEN = (PREAMBLE_LEN > MAX_PG) ? PREAMBLE_LEN : MAX_PG;
   localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int DIV_W   = $clog2(CLK_DIV);

   bpsk_state_e        state_q;
   logic [DIV_W-1:0]   div_cnt;
   logic [CNT_W-1:0]   sym_cnt;
   logic               zs_q;
   logic               tick;
   logic               last_sym;
   logic               cur_bit;
   logic               prbs_bit;
   logic [8:0]         lfsr_state;
   logic               unused_lfsr;

   logic               sym_tick_q;
   logic               bit_out_q;
   logic [1:0]         din_q;
   logic               frame_start_q;
   logic               busy_q;

   assign tick        = (state_q != IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
   assign unused_lfsr = ^lfsr_state;

   prbs9_lfsr u_prbs (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (tick && (state_q == PAYLOAD)),
      .load     (bus.load_seed && (state_q == IDLE)),
      .seed     (bus.seed),
      .prbs_bit (prbs_bit),
      .state    (lfsr_state)
   );

   always_comb begin
      cur_bit  = 1'b0;
      last_sym = 1'b0;
      case (state_q)
         PREAMBLE: begin
            cur_bit  = ~sym_cnt[0];
            last_sym = (sym_cnt == CNT_W'(PREAMBLE_LEN - 1));
         end
         PAYLOAD: begin
            cur_bit  = prbs_bit;
            last_sym = (sym_cnt == CNT_W'(PAYLOAD_LEN - 1));
         end
         GUARD:   last_sym = (sym_cnt == CNT_W'(GUARD_LEN - 1));
         default: ;
      endcase
   end

   // Divider is parked at 0 in IDLE so the first symbol of a frame gets a full period.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         div_cnt <= '0;
         sym_cnt <= '0;
         zs_q    <= 1'b0;
      end else if (state_q == IDLE) begin
         div_cnt <= '0;
         sym_cnt <= '0;
         if (bus.en) begin
            state_q <= PREAMBLE;
            zs_q    <= bus.zero_stuff;
         end
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) begin
            zs_q <= bus.zero_stuff;
            if (last_sym) begin
               sym_cnt <= '0;
               case (state_q)
                  PREAMBLE: state_q <= PAYLOAD;
                  PAYLOAD:  state_q <= GUARD;
                  default:  state_q <= bus.en ? PREAMBLE : IDLE;
               endcase
            end else begin
               sym_cnt <= sym_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sym_tick_q    <= 1'b0;
         bit_out_q     <= 1'b0;
         din_q         <= SYM_ZERO;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         sym_tick_q    <= tick;
         bit_out_q     <= cur_bit;
         busy_q        <= (state_q != IDLE);
         frame_start_q <= (state_q == PREAMBLE) && (sym_cnt == '0) && (div_cnt == '0);
         if (((state_q == PREAMBLE) || (state_q == PAYLOAD)) && (!zs_q || (div_cnt == '0)))
            din_q <= sym_map(cur_bit);
         else
            din_q <= SYM_ZERO;
      end
   end

   assign bus.sym_tick    = sym_tick_q;
   assign bus.bit_out     = bit_out_q;
   assign bus.din         = din_q;
   assign bus.frame_start = frame_start_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_bpsk_symbol_gen.sv
// Self-checking bench for bpsk_symbol_gen: per-clk output vectors are compared
// against a frame model built from symbol-level rules and the PRBS9 recurrence.
module tb_bpsk_symbol_gen;

   localparam int CLK_DIV = 17;
   localparam int PRE     = 32;
   localparam int PAY     = 256;
   localparam int GRD     = 8;
   localparam int NSYM    = PRE + PAY + GRD;
   localparam int FCLK    = NSYM * CLK_DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   bit         hist[$];
   logic [5:0] expq[$];
   logic [5:0] got[$];

   bpsk_symbol_gen_if bus ();

   bpsk_symbol_gen #(
      .CLK_DIV      (CLK_DIV),
      .PREAMBLE_LEN (PRE),
      .PAYLOAD_LEN  (PAY),
      .GUARD_LEN    (GRD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   // PRBS9 as the bit recurrence b[n+9] = b[n] ^ b[n+4]; seed MSB is the first bit out.
   function automatic void model_load(input logic [8:0] s);
      logic [8:0] v;
      v = (s == 9'd0) ? 9'h1FF : s;
      hist.delete();
      for (int i = 8; i >= 0; i--) hist.push_back(v[i]);
   endfunction

   function automatic bit model_next();
      bit b;
      b = hist[0];
      hist.push_back(hist[0] ^ hist[4]);
      void'(hist.pop_front());
      return b;
   endfunction

   function automatic logic [5:0] obs();
      return {bus.frame_start, bus.busy, bus.sym_tick, bus.bit_out, bus.din};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected vector per clk: {frame_start, busy, sym_tick, bit_out, din}.
   task automatic build_frame(input bit zs, input int lead, input int tail);
      for (int i = 0; i < lead; i++) expq.push_back(6'd0);
      for (int s = 0; s < NSYM; s++) begin
         bit         b;
         bit         guard;
         logic [1:0] d;
         guard = (s >= PRE + PAY);
         if (s < PRE)    b = ((s % 2) == 0);
         else if (!guard) b = model_next();
         else             b = 1'b0;
         for (int c = 0; c < CLK_DIV; c++) begin
            d = (guard || (zs && c != 0)) ? 2'b00 : (b ? 2'b01 : 2'b11);
            expq.push_back({(s == 0 && c == 0), 1'b1, (c == CLK_DIV - 1), b, d});
         end
      end
      for (int i = 0; i < tail; i++) expq.push_back(6'd0);
   endtask

   task automatic capture(input int n, input int glitch_at, input logic [8:0] gseed,
                          input int drop_at);
      got.delete();
      for (int i = 0; i < n; i++) begin
         step();
         got.push_back(obs());
         bus.load_seed = (i == glitch_at);
         if (i == glitch_at) bus.seed = gseed;
         if (i == drop_at) bus.en = 1'b0;
      end
   endtask

   task automatic test_reset();
      int ticks;
      rst_n = 1'b0;
      repeat (3) step();
      checks++;
      if (obs() !== 6'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", obs(), 6'd0);
      end
      rst_n = 1'b1;
      ticks = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (bus.sym_tick) ticks++;
         checks++;
         if (obs() !== 6'd0) begin
            errors++;
            $display("FAIL idle_outputs cyc %0d: got %b expected %b", i, obs(), 6'd0);
         end
      end
      checks++;
      if (ticks !== 0) begin
         errors++;
         $display("FAIL idle_sym_tick: got %0d pulses expected 0", ticks);
      end
      model_load(9'h1FF);
   endtask

   // en dropped early in the preamble: frame must still run to the end of guard, then idle.
   task automatic test_hold_frame();
      expq.delete();
      bus.zero_stuff = 1'b0;
      bus.en         = 1'b1;
      build_frame(1'b0, 1, 20);
      capture(expq.size(), -1, 9'd0, 5);
      foreach (expq[i]) begin
         checks++;
         if (got[i] !== expq[i]) begin
            errors++;
            $display("FAIL hold_frame cyc %0d: got %b expected %b", i, got[i], expq[i]);
         end
      end
   endtask

   task automatic test_zero_stuff();
      logic [8:0] s;
      s = 9'($urandom_range(1, 511));
      expq.delete();
      bus.seed       = s;
      bus.load_seed  = 1'b1;
      bus.zero_stuff = 1'b1;
      bus.en         = 1'b1;
      model_load(s);
      build_frame(1'b1, 1, 20);
      capture(expq.size(), -1, 9'd0, 0);
      foreach (expq[i]) begin
         checks++;
         if (got[i] !== expq[i]) begin
            errors++;
            $display("FAIL zero_stuff cyc %0d: got %b expected %b", i, got[i], expq[i]);
         end
      end
      bus.zero_stuff = 1'b0;
   endtask

   task automatic test_seed();
      int         pos;
      logic [8:0] junk;
      // Zero seed in IDLE falls back to all ones; a mid-payload load must be ignored.
      bus.seed      = 9'd0;
      bus.load_seed = 1'b1;
      step();
      bus.load_seed = 1'b0;
      model_load(9'd0);
      expq.delete();
      pos  = 1 + (PRE + 5) * CLK_DIV + int'($urandom_range(0, 200 * CLK_DIV));
      junk = 9'($urandom_range(1, 510));
      bus.en = 1'b1;
      build_frame(1'b0, 1, 10);
      capture(expq.size(), pos, junk, 0);
      foreach (expq[i]) begin
         checks++;
         if (got[i] !== expq[i]) begin
            errors++;
            $display("FAIL seed_zero cyc %0d: got %b expected %b", i, got[i], expq[i]);
         end
      end
      bus.seed      = 9'h001;
      bus.load_seed = 1'b1;
      step();
      bus.load_seed = 1'b0;
      model_load(9'h001);
      expq.delete();
      bus.en = 1'b1;
      build_frame(1'b0, 1, 10);
      capture(expq.size(), -1, 9'd0, 0);
      checks++;
      if (got[1 + PRE * CLK_DIV][1:0] !== 2'b11) begin
         errors++;
         $display("FAIL seed_one_first_bit: got %b expected %b",
                  got[1 + PRE * CLK_DIV][1:0], 2'b11);
      end
      foreach (expq[i]) begin
         checks++;
         if (got[i] !== expq[i]) begin
            errors++;
            $display("FAIL seed_one cyc %0d: got %b expected %b", i, got[i], expq[i]);
         end
      end
   endtask

   // en held across a frame boundary, dropped mid-payload of the second frame.
   task automatic test_back_to_back();
      bit zs;
      int drop;
      zs   = 1'($urandom_range(0, 1));
      drop = 1 + FCLK + (PRE + 10) * CLK_DIV + int'($urandom_range(0, 150 * CLK_DIV));
      expq.delete();
      bus.zero_stuff = zs;
      bus.en         = 1'b1;
      build_frame(zs, 1, 0);
      build_frame(zs, 0, 15);
      capture(expq.size(), -1, 9'd0, drop);
      foreach (expq[i]) begin
         checks++;
         if (got[i] !== expq[i]) begin
            errors++;
            $display("FAIL back_to_back cyc %0d: got %b expected %b", i, got[i], expq[i]);
         end
      end
      bus.zero_stuff = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n;
      n = int'($urandom_range(500, 3000));
      bus.en = 1'b1;
      repeat (n) step();
      bus.en = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_frame_busy: got %b expected %b", bus.busy, 1'b1);
      end
      rst_n = 1'b0;
      step();
      checks++;
      if (obs() !== 6'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %b expected %b", obs(), 6'd0);
      end
      rst_n = 1'b1;
      model_load(9'h1FF);
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (obs() !== 6'd0) begin
            errors++;
            $display("FAIL post_reset_idle cyc %0d: got %b expected %b", i, obs(), 6'd0);
         end
      end
      expq.delete();
      bus.en = 1'b1;
      build_frame(1'b0, 1, 10);
      capture(expq.size(), -1, 9'd0, 0);
      foreach (expq[i]) begin
         checks++;
         if (got[i] !== expq[i]) begin
            errors++;
            $display("FAIL post_reset_frame cyc %0d: got %b expected %b", i, got[i], expq[i]);
         end
      end
   endtask

   initial begin
      bus.en         = 1'b0;
      bus.zero_stuff = 1'b0;
      bus.seed       = 9'd0;
      bus.load_seed  = 1'b0;
      test_reset();
      test_hold_frame();
      test_zero_stuff();
      test_seed();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
